// File: rtl/regfile_pkg.sv
// Shared widths and arbiter state encoding for the register-file write path.
package regfile_pkg;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;

    typedef enum logic {
        CLEAR,
        RUN
    } arb_state_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO of {addr, data} write requests from the MDU.
// Exposes every slot's address and valid bit so the owner can build a pending mask.
module rf_wr_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [RF_ADDR_W-1:0]         i_push_addr,
    input  logic [RF_DATA_W-1:0]         i_push_data,
    input  logic                         i_pop,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [RF_ADDR_W-1:0]         o_head_addr,
    output logic [RF_DATA_W-1:0]         o_head_data,
    output logic [DEPTH*RF_ADDR_W-1:0]   o_entry_addr,
    output logic [DEPTH-1:0]             o_entry_valid
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [RF_ADDR_W-1:0] r_addr [DEPTH];
    logic [RF_DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 w_push;
    logic                 w_pop;

    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;
    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_entry_valid = r_valid;

    always_comb begin
        o_entry_addr = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_entry_addr[i*RF_ADDR_W +: RF_ADDR_W] = r_addr[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= i_push_addr;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register bank write port: zero-fills all registers after reset, then
// shares the port between writeback (priority) and buffered MDU results.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_we,
    input  logic [RF_ADDR_W-1:0] wb_addr,
    input  logic [RF_DATA_W-1:0] wb_data,
    input  logic                 mdu_valid,
    input  logic [RF_ADDR_W-1:0] mdu_addr,
    input  logic [RF_DATA_W-1:0] mdu_data,
    output logic                 mdu_ready,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_a3,
    output logic [RF_DATA_W-1:0] rf_wd3,
    output logic                 busy,
    output logic                 wb_stall,
    output logic [NUM_REGS-1:0]  pend_mask
);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t                        r_state;
    logic [RF_ADDR_W-1:0]              r_clr_cnt;
    logic [STV_W-1:0]                  r_starve;
    logic                              r_wb_stall;

    logic                              w_run;
    logic                              w_wb_win;
    logic                              w_push;
    logic                              w_pop;
    logic                              w_full;
    logic                              w_empty;
    logic [RF_ADDR_W-1:0]              w_head_addr;
    logic [RF_DATA_W-1:0]              w_head_data;
    logic [FIFO_DEPTH*RF_ADDR_W-1:0]   w_entry_addr;
    logic [FIFO_DEPTH-1:0]             w_entry_valid;
    logic [STV_W-1:0]                  w_starve_nxt;

    assign w_run     = (r_state == RUN);
    assign w_wb_win  = w_run && wb_we && (wb_addr != '0);
    assign w_pop     = w_run && !w_wb_win && !w_empty;
    assign mdu_ready = w_run && !w_full;
    assign w_push    = mdu_valid && mdu_ready;
    assign busy      = (r_state == CLEAR);
    assign wb_stall  = r_wb_stall;

    rf_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_push        (w_push),
        .i_push_addr   (mdu_addr),
        .i_push_data   (mdu_data),
        .i_pop         (w_pop),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_entry_addr  (w_entry_addr),
        .o_entry_valid (w_entry_valid)
    );

    // Head entries for r0 still pop, but never reach the bank.
    always_comb begin
        rf_we  = 1'b0;
        rf_a3  = '0;
        rf_wd3 = '0;
        if (r_state == CLEAR) begin
            rf_we = 1'b1;
            rf_a3 = r_clr_cnt;
        end else if (w_wb_win) begin
            rf_we  = 1'b1;
            rf_a3  = wb_addr;
            rf_wd3 = wb_data;
        end else if (w_pop && (w_head_addr != '0)) begin
            rf_we  = 1'b1;
            rf_a3  = w_head_addr;
            rf_wd3 = w_head_data;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                pend_mask[w_entry_addr[i*RF_ADDR_W +: RF_ADDR_W]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    // Saturates at the limit so a writeback that ignores the stall keeps it asserted.
    always_comb begin
        w_starve_nxt = r_starve;
        if (!w_run || w_empty || w_pop) begin
            w_starve_nxt = '0;
        end else if (r_starve != STV_W'(STARVE_LIMIT)) begin
            w_starve_nxt = r_starve + STV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CLEAR;
            r_clr_cnt  <= '0;
            r_starve   <= '0;
            r_wb_stall <= 1'b0;
        end else begin
            unique case (r_state)
                CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + RF_ADDR_W'(1);
                    if (r_clr_cnt == RF_ADDR_W'(NUM_REGS - 1)) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                default: r_state <= CLEAR;
            endcase
            r_starve   <= w_starve_nxt;
            r_wb_stall <= (w_starve_nxt == STV_W'(STARVE_LIMIT));
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scenario bench for regfile_write_arbiter with a queue scoreboard of expected MDU writes.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_addr = '0;
    logic [31:0] mdu_data = '0;
    logic        mdu_ready, rf_we, busy, wb_stall;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3, pend_mask;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [36:0] sb[$];
    logic [36:0] exp_e;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .mdu_valid (mdu_valid),
        .mdu_addr  (mdu_addr),
        .mdu_data  (mdu_data),
        .mdu_ready (mdu_ready),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3),
        .busy      (busy),
        .wb_stall  (wb_stall),
        .pend_mask (pend_mask)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (sb[k]) if (sb[k][36:32] != 5'd0) m[sb[k][36:32]] = 1'b1;
        return m;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        #2;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", busy); end
        n_tests++; if (mdu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", mdu_ready); end
        n_tests++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", wb_stall); end
        n_tests++; if (pend_mask !== 32'h0) begin n_fail++; $display("FAIL rst_pend: got %h want 0", pend_mask); end
        n_tests++; if ({rf_we, rf_a3, rf_wd3} !== {1'b1, 5'd0, 32'd0}) begin n_fail++; $display("FAIL rst_port: got we=%b a3=%0d wd=%h want 1/0/0", rf_we, rf_a3, rf_wd3); end
    endtask

    task automatic test_clear();
        rst = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hFFFF_FFFF;
        mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h9;
        for (int i = 0; i < 32; i++) begin
            #2;
            n_tests++; if ({rf_we, rf_a3, rf_wd3} !== {1'b1, 5'(i), 32'd0}) begin n_fail++; $display("FAIL clear_write[%0d]: got we=%b a3=%0d wd=%h want 1/%0d/0", i, rf_we, rf_a3, rf_wd3, i); end
            n_tests++; if ({busy, mdu_ready} !== 2'b10) begin n_fail++; $display("FAIL clear_hold[%0d]: got busy=%b ready=%b want 1/0", i, busy, mdu_ready); end
            step();
        end
        wb_we = 1'b0; mdu_valid = 1'b0;
        #2;
        n_tests++; if ({busy, mdu_ready} !== 2'b01) begin n_fail++; $display("FAIL clear_done: got busy=%b ready=%b want 0/1", busy, mdu_ready); end
        n_tests++; if ({rf_we, pend_mask} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL clear_idle: got we=%b pend=%h want 0/0", rf_we, pend_mask); end
        step();
    endtask

    task automatic test_wb_mdu();
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h1234;
        #2;
        n_tests++; if ({rf_we, rf_a3, rf_wd3} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL wb_pass: got we=%b a3=%0d wd=%h want 1/5/deadbeef", rf_we, rf_a3, rf_wd3); end
        n_tests++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL wb_mdu_ready: got %b want 1", mdu_ready); end
        sb.push_back({mdu_addr, mdu_data});
        step();
        wb_we = 1'b0; mdu_valid = 1'b0;
        #2;
        n_tests++; if (pend_mask !== 32'h80 || pend_mask !== model_mask()) begin n_fail++; $display("FAIL wb_mdu_pend: got %h want %h", pend_mask, model_mask()); end
        exp_e = sb.pop_front();
        n_tests++; if ({rf_we, rf_a3, rf_wd3} !== {1'b1, exp_e}) begin n_fail++; $display("FAIL wb_mdu_drain: got we=%b a3=%0d wd=%h want 1/%0d/%h", rf_we, rf_a3, rf_wd3, exp_e[36:32], exp_e[31:0]); end
        step();
        #2;
        n_tests++; if ({rf_we, pend_mask} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL wb_mdu_after: got we=%b pend=%h want 0/0", rf_we, pend_mask); end
        step();
    endtask

    task automatic test_starve();
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5_0009;
        mdu_valid = 1'b1; mdu_addr = 5'd3; mdu_data = 32'h33;
        #2;
        n_tests++; if ({mdu_ready, rf_a3} !== {1'b1, 5'd9}) begin n_fail++; $display("FAIL stv_acc1: got ready=%b a3=%0d want 1/9", mdu_ready, rf_a3); end
        sb.push_back({mdu_addr, mdu_data});
        step();
        mdu_addr = 5'd4; mdu_data = 32'h44;
        #2;
        n_tests++; if ({mdu_ready, pend_mask} !== {1'b1, model_mask()}) begin n_fail++; $display("FAIL stv_acc2: got ready=%b pend=%h want 1/%h", mdu_ready, pend_mask, model_mask()); end
        sb.push_back({mdu_addr, mdu_data});
        step();
        mdu_valid = 1'b0;
        #2;
        n_tests++; if ({mdu_ready, pend_mask} !== {1'b0, 32'h18}) begin n_fail++; $display("FAIL stv_full: got ready=%b pend=%h want 0/18", mdu_ready, pend_mask); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) #2;
            n_tests++; if ({wb_stall, rf_a3} !== {1'b0, 5'd9}) begin n_fail++; $display("FAIL stv_wait[%0d]: got stall=%b a3=%0d want 0/9", i, wb_stall, rf_a3); end
            step();
        end
        #2;
        n_tests++; if ({wb_stall, rf_we, rf_a3} !== {1'b1, 1'b1, 5'd9}) begin n_fail++; $display("FAIL stv_violate: got stall=%b we=%b a3=%0d want 1/1/9", wb_stall, rf_we, rf_a3); end
        step();
        wb_we = 1'b0;
        #2;
        n_tests++; if (wb_stall !== 1'b1) begin n_fail++; $display("FAIL stv_hold: got %b want 1", wb_stall); end
        exp_e = sb.pop_front();
        n_tests++; if ({rf_we, rf_a3, rf_wd3} !== {1'b1, exp_e}) begin n_fail++; $display("FAIL stv_drain3: got we=%b a3=%0d wd=%h want 1/%0d/%h", rf_we, rf_a3, rf_wd3, exp_e[36:32], exp_e[31:0]); end
        step();
        #2;
        n_tests++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL stv_release: got %b want 0", wb_stall); end
        exp_e = sb.pop_front();
        n_tests++; if ({rf_we, rf_a3, rf_wd3} !== {1'b1, exp_e}) begin n_fail++; $display("FAIL stv_drain4: got we=%b a3=%0d wd=%h want 1/%0d/%h", rf_we, rf_a3, rf_wd3, exp_e[36:32], exp_e[31:0]); end
        step();
        #2;
        n_tests++; if ({rf_we, pend_mask} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL stv_empty: got we=%b pend=%h want 0/0", rf_we, pend_mask); end
        step();
    endtask

    task automatic test_full_pop();
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h9;
        mdu_valid = 1'b1; mdu_addr = 5'd10; mdu_data = 32'hA;
        #2;
        sb.push_back({mdu_addr, mdu_data});
        step();
        mdu_addr = 5'd11; mdu_data = 32'hB;
        #2;
        sb.push_back({mdu_addr, mdu_data});
        step();
        wb_we = 1'b0; mdu_addr = 5'd12; mdu_data = 32'hC;
        #2;
        n_tests++; if (mdu_ready !== 1'b0) begin n_fail++; $display("FAIL fp_refuse: got ready=%b want 0", mdu_ready); end
        n_tests++; if (pend_mask !== model_mask()) begin n_fail++; $display("FAIL fp_pend_full: got %h want %h", pend_mask, model_mask()); end
        exp_e = sb.pop_front();
        n_tests++; if ({rf_we, rf_a3, rf_wd3} !== {1'b1, exp_e}) begin n_fail++; $display("FAIL fp_drain10: got we=%b a3=%0d wd=%h want 1/%0d/%h", rf_we, rf_a3, rf_wd3, exp_e[36:32], exp_e[31:0]); end
        step();
        #2;
        n_tests++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL fp_accept: got ready=%b want 1", mdu_ready); end
        n_tests++; if (pend_mask !== model_mask()) begin n_fail++; $display("FAIL fp_pend_one: got %h want %h", pend_mask, model_mask()); end
        exp_e = sb.pop_front();
        n_tests++; if ({rf_we, rf_a3, rf_wd3} !== {1'b1, exp_e}) begin n_fail++; $display("FAIL fp_drain11: got we=%b a3=%0d wd=%h want 1/%0d/%h", rf_we, rf_a3, rf_wd3, exp_e[36:32], exp_e[31:0]); end
        sb.push_back({mdu_addr, mdu_data});
        step();
        mdu_valid = 1'b0;
        #2;
        n_tests++; if (pend_mask !== 32'h1000 || pend_mask !== model_mask()) begin n_fail++; $display("FAIL fp_pend12: got %h want %h", pend_mask, model_mask()); end
        exp_e = sb.pop_front();
        n_tests++; if ({rf_we, rf_a3, rf_wd3} !== {1'b1, exp_e}) begin n_fail++; $display("FAIL fp_drain12: got we=%b a3=%0d wd=%h want 1/%0d/%h", rf_we, rf_a3, rf_wd3, exp_e[36:32], exp_e[31:0]); end
        step();
        #2;
        n_tests++; if ({rf_we, pend_mask} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL fp_empty: got we=%b pend=%h want 0/0", rf_we, pend_mask); end
        step();
    endtask

    task automatic test_addr0();
        wb_we = 1'b0;
        mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h55;
        #2;
        n_tests++; if ({mdu_ready, rf_we} !== 2'b10) begin n_fail++; $display("FAIL a0_accept: got ready=%b we=%b want 1/0", mdu_ready, rf_we); end
        sb.push_back({mdu_addr, mdu_data});
        step();
        mdu_valid = 1'b0;
        #2;
        n_tests++; if (pend_mask !== 32'h0) begin n_fail++; $display("FAIL a0_pend: got %h want 0", pend_mask); end
        exp_e = sb.pop_front();
        n_tests++; if ({rf_we, rf_a3} !== {1'b0, exp_e[36:32]}) begin n_fail++; $display("FAIL a0_pop: got we=%b a3=%0d want 0/0", rf_we, rf_a3); end
        step();
        wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h8;
        mdu_valid = 1'b1; mdu_addr = 5'd6; mdu_data = 32'h66;
        #2;
        n_tests++; if ({mdu_ready, pend_mask, rf_a3} !== {1'b1, 32'h0, 5'd8}) begin n_fail++; $display("FAIL a0_empty: got ready=%b pend=%h a3=%0d want 1/0/8", mdu_ready, pend_mask, rf_a3); end
        sb.push_back({mdu_addr, mdu_data});
        step();
        wb_addr = 5'd0; wb_data = 32'hFFFF;
        mdu_valid = 1'b0;
        #2;
        n_tests++; if (pend_mask !== model_mask()) begin n_fail++; $display("FAIL wb0_pend: got %h want %h", pend_mask, model_mask()); end
        exp_e = sb.pop_front();
        n_tests++; if ({rf_we, rf_a3, rf_wd3} !== {1'b1, exp_e}) begin n_fail++; $display("FAIL wb0_drain: got we=%b a3=%0d wd=%h want 1/%0d/%h", rf_we, rf_a3, rf_wd3, exp_e[36:32], exp_e[31:0]); end
        step();
        wb_we = 1'b0;
        #2;
        n_tests++; if ({rf_we, pend_mask} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL wb0_idle: got we=%b pend=%h want 0/0", rf_we, pend_mask); end
        step();
    endtask

    task automatic test_rst_midclear();
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h9;
        mdu_valid = 1'b1; mdu_addr = 5'd13; mdu_data = 32'hD;
        #2;
        sb.push_back({mdu_addr, mdu_data});
        step();
        rst = 1'b1; wb_we = 1'b0; mdu_valid = 1'b0;
        step();
        sb.delete();
        rst = 1'b0;
        #2;
        n_tests++; if ({pend_mask, busy} !== {32'h0, 1'b1}) begin n_fail++; $display("FAIL rr_flush: got pend=%h busy=%b want 0/1", pend_mask, busy); end
        for (int i = 0; i < 18; i++) begin
            if (i > 0) #2;
            if (i == 17) rst = 1'b1;
            n_tests++; if (rf_a3 !== 5'(i)) begin n_fail++; $display("FAIL rr_first[%0d]: got a3=%0d want %0d", i, rf_a3, i); end
            step();
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #2;
            n_tests++; if ({rf_we, rf_a3, rf_wd3, busy} !== {1'b1, 5'(i), 32'd0, 1'b1}) begin n_fail++; $display("FAIL rr_clear[%0d]: got we=%b a3=%0d wd=%h busy=%b want 1/%0d/0/1", i, rf_we, rf_a3, rf_wd3, busy, i); end
            step();
        end
        #2;
        n_tests++; if ({busy, mdu_ready, pend_mask} !== {1'b0, 1'b1, 32'h0}) begin n_fail++; $display("FAIL rr_done: got busy=%b ready=%b pend=%h want 0/1/0", busy, mdu_ready, pend_mask); end
        step();
    endtask

    initial begin
        test_reset();
        test_clear();
        test_wb_mdu();
        test_starve();
        test_full_pop();
        test_addr0();
        test_rst_midclear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
